// File: rtl/rr_read_port_arbiter.sv
// Shares NUM_PORTS register-file read ports among NUM_REQ requesters: round-robin grants with
// starvation promotion and same-address merging, and one-cycle steering of RF data back to the granted requesters.
module rr_read_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        recoverFlag_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_PORTS-1:0]        rf_en_o,
  output logic [NUM_PORTS*ADDR_W-1:0] rf_addr_o,
  input  logic [NUM_PORTS*DATA_W-1:0] rf_data_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_data_o
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]       LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  logic [ADDR_W-1:0] req_addr [NUM_REQ];
  logic [DATA_W-1:0] rf_data  [NUM_PORTS];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_addr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign rf_data[g] = rf_data_i[g*DATA_W +: DATA_W];
  end

  logic [PTR_W-1:0]   rr_ptr;
  logic [3:0]         age [NUM_REQ];
  logic [NUM_REQ-1:0] starving;

  logic [NUM_REQ-1:0]   grant_p0;
  logic [PORT_W-1:0]    grant_port_p0 [NUM_REQ];
  logic [NUM_PORTS-1:0] port_used_p0;
  logic [ADDR_W-1:0]    port_addr_p0 [NUM_PORTS];
  logic                 rr_hit_p0;
  logic [PTR_W-1:0]     rr_last_p0;
  logic                 grant_en;

  logic [NUM_REQ-1:0] vld_p1;
  logic [PORT_W-1:0]  port_p1 [NUM_REQ];

  assign grant_en = !reset && !recoverFlag_i;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starving[i] = req_valid_i[i] && (age[i] >= LIMIT);
    end
  end

  // ---- stage p0: service-order walk and port assignment ----
  // Slots 0..NUM_REQ-1 visit starving requesters by index; the remaining slots
  // visit non-starving valid requesters in round-robin order from rr_ptr.
  always_comb begin : arb
    logic [PTR_W-1:0] idx;
    logic             cand;
    logic             placed;
    idx           = '0;
    cand          = 1'b0;
    placed        = 1'b0;
    grant_p0      = '0;
    port_used_p0  = '0;
    rr_hit_p0     = 1'b0;
    rr_last_p0    = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_port_p0[i] = '0;
    for (int p = 0; p < NUM_PORTS; p++) port_addr_p0[p] = '0;
    for (int k = 0; k < 2*NUM_REQ; k++) begin
      if (k < NUM_REQ) begin
        idx  = PTR_W'(k);
        cand = starving[idx];
      end else begin
        idx  = PTR_W'((int'(rr_ptr) + k - NUM_REQ) % NUM_REQ);
        cand = req_valid_i[idx] && !starving[idx];
      end
      placed = 1'b0;
      if (cand) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!placed && port_used_p0[p] && (port_addr_p0[p] == req_addr[idx])) begin
            placed             = 1'b1;
            grant_p0[idx]      = 1'b1;
            grant_port_p0[idx] = PORT_W'(p);
          end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!placed && !port_used_p0[p]) begin
            placed             = 1'b1;
            port_used_p0[p]    = 1'b1;
            port_addr_p0[p]    = req_addr[idx];
            grant_p0[idx]      = 1'b1;
            grant_port_p0[idx] = PORT_W'(p);
          end
        end
        if (placed && (k >= NUM_REQ)) begin
          rr_hit_p0  = 1'b1;
          rr_last_p0 = idx;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    rf_en_o     = '0;
    rf_addr_o   = '0;
    if (grant_en) begin
      req_ready_o = grant_p0;
      rf_en_o     = port_used_p0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_used_p0[p]) rf_addr_o[p*ADDR_W +: ADDR_W] = port_addr_p0[p];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      vld_p1 <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        age[i]     <= '0;
        port_p1[i] <= '0;
      end
    end else begin
      vld_p1 <= recoverFlag_i ? '0 : grant_p0;
      if (!recoverFlag_i && rr_hit_p0) begin
        rr_ptr <= (rr_last_p0 == LAST_REQ) ? '0 : rr_last_p0 + PTR_W'(1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        port_p1[i] <= grant_port_p0[i];
        if (recoverFlag_i || !req_valid_i[i] || grant_p0[i]) begin
          age[i] <= '0;
        end else if (age[i] != 4'hF) begin
          age[i] <= age[i] + 4'd1;
        end
      end
    end
  end

  // ---- stage p1: steer live RF data by the registered port index ----
  assign rsp_valid_o = vld_p1;

  always_comb begin
    rsp_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (vld_p1[i] && (port_p1[i] == PORT_W'(p))) begin
          rsp_data_o[i*DATA_W +: DATA_W] = rf_data[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_read_port_arbiter.sv
// Directed bench for rr_read_port_arbiter: a 2-port and a 1-port instance, each with an emulated
// register file and a response scoreboard.
module tb_rr_read_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   v0, v1;
  logic [27:0]  a0, a1;
  logic         fl0, fl1;
  logic [3:0]   rdy0, rdy1, rv0, rv1;
  logic [1:0]   en0;
  logic [0:0]   en1;
  logic [13:0]  ra0;
  logic [6:0]   ra1;
  logic [127:0] rd0;
  logic [63:0]  rd1;
  logic [255:0] rsd0, rsd1;

  rr_read_port_arbiter u0 (
    .clk(clk), .reset(rst), .recoverFlag_i(fl0),
    .req_valid_i(v0), .req_addr_i(a0), .req_ready_o(rdy0),
    .rf_en_o(en0), .rf_addr_o(ra0), .rf_data_i(rd0),
    .rsp_valid_o(rv0), .rsp_data_o(rsd0)
  );

  rr_read_port_arbiter #(.NUM_PORTS(1)) u1 (
    .clk(clk), .reset(rst), .recoverFlag_i(fl1),
    .req_valid_i(v1), .req_addr_i(a1), .req_ready_o(rdy1),
    .rf_en_o(en1), .rf_addr_o(ra1), .rf_data_i(rd1),
    .rsp_valid_o(rv1), .rsp_data_o(rsd1)
  );

  function automatic logic [63:0] rfv(input logic [6:0] a);
    return {a, 1'b0, 24'h5A5A5A, a, 1'b1, 24'hC3C3C3};
  endfunction

  // Register file: the address presented on an enabled port returns its contents one cycle later.
  logic [1:0]  q_en0;
  logic [13:0] q_a0;
  logic [0:0]  q_en1;
  logic [6:0]  q_a1;
  always @(posedge clk) begin
    q_en0 <= en0; q_a0 <= ra0;
    q_en1 <= en1; q_a1 <= ra1;
  end
  assign rd0 = {q_en0[1] ? rfv(q_a0[13:7]) : 64'h0BAD_0BAD_0BAD_0BAD,
                q_en0[0] ? rfv(q_a0[6:0])  : 64'h0BAD_0BAD_0BAD_0BAD};
  assign rd1 = q_en1[0] ? rfv(q_a1) : 64'h0BAD_0BAD_0BAD_0BAD;

  typedef struct packed {
    logic [3:0]   mask;
    logic [255:0] data;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input logic [3:0] m, input logic [27:0] a);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) if (m[i]) d[i*64 +: 64] = rfv(a[i*7 +: 7]);
    return d;
  endfunction

  function automatic logic [27:0] pk(input int a3, input int a2, input int a1_, input int a0_);
    return {7'(a3), 7'(a2), 7'(a1_), 7'(a0_)};
  endfunction

  // One cycle on instance inst: drive, check grant outputs and the response due now, queue the next response.
  task automatic step(input int inst, input logic [3:0] v, input logic [27:0] a, input logic fl,
                      input logic [3:0] er, input logic [1:0] ee, input logic [13:0] ea, input string tag);
    exp_t e;
    @(negedge clk);
    if (inst == 0) begin
      v0 = v; a0 = a; fl0 = fl; v1 = '0; a1 = '0; fl1 = 1'b0;
    end else begin
      v1 = v; a1 = a; fl1 = fl; v0 = '0; a0 = '0; fl0 = 1'b0;
    end
    #1;
    e = '0;
    if (inst == 0) begin
      chk({tag, " ready"}, 256'(rdy0), 256'(er));
      chk({tag, " rf_en"}, 256'(en0), 256'(ee));
      chk({tag, " rf_addr"}, 256'(ra0), 256'(ea));
      if (sb0.size() > 0) e = sb0.pop_front();
      chk({tag, " rsp_valid"}, 256'(rv0), 256'(e.mask));
      chk({tag, " rsp_data"}, rsd0, e.data);
      e.mask = er; e.data = exp_data(er, a);
      sb0.push_back(e);
    end else begin
      chk({tag, " ready"}, 256'(rdy1), 256'(er));
      chk({tag, " rf_en"}, 256'(en1), 256'(ee));
      chk({tag, " rf_addr"}, 256'(ra1), 256'(ea));
      if (sb1.size() > 0) e = sb1.pop_front();
      chk({tag, " rsp_valid"}, 256'(rv1), 256'(e.mask));
      chk({tag, " rsp_data"}, rsd1, e.data);
      e.mask = er; e.data = exp_data(er, a);
      sb1.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v0 = 4'b1111; a0 = pk(13, 12, 11, 10); fl0 = 1'b0;
    v1 = 4'b1111; a1 = pk(13, 12, 11, 10); fl1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", 256'(rdy0), 256'(0));
    chk("reset rf_en", 256'(en0), 256'(0));
    chk("reset rf_addr", 256'(ra0), 256'(0));
    chk("reset rsp_valid", 256'(rv0), 256'(0));
    chk("reset rsp_data", rsd0, 256'(0));
    chk("reset ready u1", 256'(rdy1), 256'(0));
    v0 = '0; v1 = '0;
    @(negedge clk);
    rst = 1'b0;

    // Two ports, distinct addresses: rr_ptr 0 -> 2 -> 0
    step(0, 4'b1111, pk(13, 12, 11, 10), 1'b0, 4'b0011, 2'b11, {7'd11, 7'd10}, "rr0");
    step(0, 4'b1111, pk(13, 12, 11, 10), 1'b0, 4'b1100, 2'b11, {7'd13, 7'd12}, "rr2");
    // Merge: 0 and 1 share address 5
    step(0, 4'b0111, pk(0, 9, 5, 5), 1'b0, 4'b0111, 2'b11, {7'd9, 7'd5}, "merge");
    // Lone requester 2, back-to-back
    step(0, 4'b0100, pk(0, 20, 0, 0), 1'b0, 4'b0100, 2'b01, {7'd0, 7'd20}, "solo a");
    step(0, 4'b0100, pk(0, 21, 0, 0), 1'b0, 4'b0100, 2'b01, {7'd0, 7'd21}, "solo b");
    step(0, 4'b0100, pk(0, 22, 0, 0), 1'b0, 4'b0100, 2'b01, {7'd0, 7'd22}, "solo c");
    // rr_ptr is 3 after the lone grants
    step(0, 4'b1111, pk(33, 32, 31, 30), 1'b0, 4'b1001, 2'b11, {7'd30, 7'd33}, "ptr3");
    // Grant, then flush on the following cycle
    step(0, 4'b0110, pk(0, 41, 40, 0), 1'b0, 4'b0110, 2'b11, {7'd41, 7'd40}, "pre flush");
    step(0, 4'b1111, pk(53, 52, 51, 50), 1'b1, 4'b0000, 2'b00, 14'd0, "flush");
    step(0, 4'b0000, 28'd0, 1'b0, 4'b0000, 2'b00, 14'd0, "post flush");
    step(0, 4'b1111, pk(63, 62, 61, 60), 1'b0, 4'b1001, 2'b11, {7'd60, 7'd63}, "ptr held");
    step(0, 4'b1111, pk(73, 72, 71, 70), 1'b0, 4'b0110, 2'b11, {7'd72, 7'd71}, "pre reset");
    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("async ready", 256'(rdy0), 256'(0));
    chk("async rf_en", 256'(en0), 256'(0));
    chk("async rf_addr", 256'(ra0), 256'(0));
    chk("async rsp_valid", 256'(rv0), 256'(0));
    chk("async rsp_data", rsd0, 256'(0));
    @(negedge clk);
    v0 = '0;
    rst = 1'b0;
    sb0.delete();
    step(0, 4'b1111, pk(83, 82, 81, 80), 1'b0, 4'b0011, 2'b11, {7'd81, 7'd80}, "after reset");
    step(0, 4'b0000, 28'd0, 1'b0, 4'b0000, 2'b00, 14'd0, "drain0");

    // One port: 0 and 1 share address 3 and keep rr_ptr at 1, so 3 (address 9) waits for promotion
    step(1, 4'b0001, pk(0, 0, 0, 3), 1'b0, 4'b0001, 2'b01, 14'd3, "s prime");
    for (int c = 1; c <= 6; c++) begin
      step(1, 4'b1011, pk(9, 0, 3, 3), 1'b0, 4'b0011, 2'b01, 14'd3, $sformatf("s deny%0d", c));
    end
    step(1, 4'b1011, pk(9, 0, 3, 3), 1'b0, 4'b1000, 2'b01, 14'd9, "s promote");
    step(1, 4'b1011, pk(9, 0, 3, 3), 1'b0, 4'b0011, 2'b01, 14'd3, "s age clear");
    for (int c = 1; c <= 5; c++) begin
      step(1, 4'b1011, pk(9, 0, 3, 3), 1'b0, 4'b0011, 2'b01, 14'd3, $sformatf("s rebuild%0d", c));
    end
    // Flush clears the accumulated age of requester 3
    step(1, 4'b1011, pk(9, 0, 3, 3), 1'b1, 4'b0000, 2'b00, 14'd0, "s flush");
    step(1, 4'b1011, pk(9, 0, 3, 3), 1'b0, 4'b0011, 2'b01, 14'd3, "s flushed age");
    step(1, 4'b0000, 28'd0, 1'b0, 4'b0000, 2'b00, 14'd0, "drain1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
